// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_if
//  Function : Two-requester (ic/dc) line-access bus plus line-memory port
//             shared between the requesters, the arbiter and the memory.
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int WIDTH = 128,
    parameter int ADDR  = 32
);
    // Instruction-side requester
    logic             ic_req;
    logic             ic_write;
    logic [ADDR-1:0]  ic_addr;
    logic [WIDTH-1:0] ic_wdata;
    logic             ic_ack;
    logic [WIDTH-1:0] ic_rdata;

    // Data-side requester
    logic             dc_req;
    logic             dc_write;
    logic [ADDR-1:0]  dc_addr;
    logic [WIDTH-1:0] dc_wdata;
    logic             dc_ack;
    logic [WIDTH-1:0] dc_rdata;

    // Line memory
    logic [ADDR-1:0]  mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_read;
    logic             mem_write;
    logic [WIDTH-1:0] mem_rdata;

    // Status
    logic             busy;

    // Arbiter side: serves the requesters and drives the memory
    modport slave (
        input  ic_req, ic_write, ic_addr, ic_wdata,
        output ic_ack, ic_rdata,
        input  dc_req, dc_write, dc_addr, dc_wdata,
        output dc_ack, dc_rdata,
        output mem_addr, mem_wdata, mem_read, mem_write,
        input  mem_rdata,
        output busy
    );

    // Environment side: requesters plus the line memory
    modport master (
        output ic_req, ic_write, ic_addr, ic_wdata,
        input  ic_ack, ic_rdata,
        output dc_req, dc_write, dc_addr, dc_wdata,
        input  dc_ack, dc_rdata,
        input  mem_addr, mem_wdata, mem_read, mem_write,
        output mem_rdata,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Function : Round-robin arbiter granting one of two requesters (ic, dc)
//             a fixed-latency line access; IDLE -> BUSY -> DONE per access.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int WIDTH   = 128,
    parameter int ADDR    = 32,
    parameter int LATENCY = 4
) (
    input  wire logic    clk,
    input  wire logic    reset,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter starts at LATENCY-1 so that LATENCY BUSY cycles elapse
    localparam logic [7:0] c_CNT_INIT = 8'(LATENCY - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_write;     // latched direction of the granted access
    logic        r_grant_dc;  // 1 = dc owns the current access
    logic        r_last_dc;   // 1 = dc was granted most recently

    logic             w_pick_dc;
    logic             w_sel_write;
    logic [ADDR-1:0]  w_sel_addr;
    logic [WIDTH-1:0] w_sel_wdata;

    // Round-robin pick: a lone requester wins; on a tie the one not granted last wins
    always_comb begin
        w_pick_dc   = bus.dc_req && (!bus.ic_req || !r_last_dc);
        w_sel_write = w_pick_dc ? bus.dc_write : bus.ic_write;
        w_sel_addr  = w_pick_dc ? bus.dc_addr  : bus.ic_addr;
        w_sel_wdata = w_pick_dc ? bus.dc_wdata : bus.ic_wdata;
    end

    // Arbitration FSM with all outputs registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_cnt          <= 8'd0;
            r_write        <= 1'b0;
            r_grant_dc     <= 1'b0;
            r_last_dc      <= 1'b0;
            bus.ic_ack     <= 1'b0;
            bus.dc_ack     <= 1'b0;
            bus.ic_rdata   <= '0;
            bus.dc_rdata   <= '0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.mem_read   <= 1'b0;
            bus.mem_write  <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.ic_req || bus.dc_req) begin
                        r_grant_dc    <= w_pick_dc;
                        r_last_dc     <= w_pick_dc;
                        r_write       <= w_sel_write;
                        bus.mem_addr  <= w_sel_addr;
                        bus.mem_wdata <= w_sel_wdata;
                        r_cnt         <= c_CNT_INIT;
                        // Reads assert mem_read for the whole BUSY window
                        bus.mem_read  <= !w_sel_write;
                        // A single-cycle BUSY window is also the write-strobe cycle
                        bus.mem_write <= w_sel_write && (c_CNT_INIT == 8'd0);
                        bus.busy      <= 1'b1;
                        r_state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt == 8'd0) begin
                        bus.mem_read  <= 1'b0;
                        bus.mem_write <= 1'b0;
                        if (!r_write) begin
                            if (r_grant_dc) bus.dc_rdata <= bus.mem_rdata;
                            else            bus.ic_rdata <= bus.mem_rdata;
                        end
                        if (r_grant_dc) bus.dc_ack <= 1'b1;
                        else            bus.ic_ack <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt         <= r_cnt - 8'd1;
                        // Strobe lands in the cycle where the counter reads zero
                        bus.mem_write <= r_write && (r_cnt == 8'd1);
                    end
                end
                DONE: begin
                    bus.ic_ack <= 1'b0;
                    bus.dc_ack <= 1'b0;
                    bus.busy   <= 1'b0;
                    r_state    <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Function : Directed self-checking bench for mem_arbiter (LATENCY 4 and 1).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   n_viol;

    mem_arbiter_if #(.WIDTH(128), .ADDR(32)) bus4 ();
    mem_arbiter_if #(.WIDTH(128), .ADDR(32)) bus1 ();

    mem_arbiter #(.WIDTH(128), .ADDR(32), .LATENCY(4)) u_dut4 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus4)
    );

    mem_arbiter #(.WIDTH(128), .ADDR(32), .LATENCY(1)) u_dut1 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line memory contents seen by both arbiters
    function automatic logic [127:0] mem_model(input logic [31:0] a);
        if (a == 32'h10) return {16{8'hA5}};
        return {4{a ^ 32'hC0DE_0000}};
    endfunction

    always_comb bus4.mem_rdata = mem_model(bus4.mem_addr);
    always_comb bus1.mem_rdata = mem_model(bus1.mem_addr);

    // Exclusivity watch: dual acks or simultaneous read/write strobes
    always @(negedge clk) begin
        if ((bus4.ic_ack && bus4.dc_ack) || (bus4.mem_read && bus4.mem_write) ||
            (bus1.ic_ack && bus1.dc_ack) || (bus1.mem_read && bus1.mem_write))
            n_viol++;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Follow one dut4 access until an ack appears or the budget runs out
    task automatic observe(input int max_cyc, input int mod_cyc,
                           output int ack_cyc, output int rd_cnt, output int wr_cnt,
                           output int ic_acks, output int dc_acks,
                           output logic [31:0] wr_addr, output logic [127:0] wr_data);
        ack_cyc = -1; rd_cnt = 0; wr_cnt = 0; ic_acks = 0; dc_acks = 0;
        wr_addr = '0; wr_data = '0;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk);
            if (k == mod_cyc) begin
                bus4.dc_req  = 1'b0;
                bus4.dc_addr = 32'h99;
            end
            if (bus4.mem_read) rd_cnt++;
            if (bus4.mem_write) begin
                wr_cnt++;
                wr_addr = bus4.mem_addr;
                wr_data = bus4.mem_wdata;
            end
            if (bus4.ic_ack) ic_acks++;
            if (bus4.dc_ack) dc_acks++;
            if (bus4.ic_ack || bus4.dc_ack) begin
                ack_cyc = k;
                break;
            end
        end
    endtask

    task automatic clear_inputs();
        bus4.ic_req = 0; bus4.ic_write = 0; bus4.ic_addr = '0; bus4.ic_wdata = '0;
        bus4.dc_req = 0; bus4.dc_write = 0; bus4.dc_addr = '0; bus4.dc_wdata = '0;
        bus1.ic_req = 0; bus1.ic_write = 0; bus1.ic_addr = '0; bus1.ic_wdata = '0;
        bus1.dc_req = 0; bus1.dc_write = 0; bus1.dc_addr = '0; bus1.dc_wdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drop both requests at the ack cycle and move into the following IDLE cycle
    task automatic finish_txn();
        bus4.ic_req = 0;
        bus4.dc_req = 0;
        @(negedge clk);
    endtask

    int            ack_cyc, rd_cnt, wr_cnt, ic_acks, dc_acks;
    logic [31:0]   wr_addr;
    logic [127:0]  wr_data;
    logic [11:0]   ack_v, busy_v, rd_v;
    int            wr1_cnt, wr1_pos;

    initial begin
        n_cmp = 0; n_err = 0; n_viol = 0;
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_busy",   bus4.busy, 0);
        check("rst_ack",    {bus4.ic_ack, bus4.dc_ack}, 0);
        check("rst_mem",    {bus4.mem_read, bus4.mem_write}, 0);
        check("rst_addr",   bus4.mem_addr, 0);
        check("rst_rdata",  bus4.dc_rdata | bus4.ic_rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Lone dc read of 0x10
        bus4.dc_req = 1; bus4.dc_write = 0; bus4.dc_addr = 32'h10;
        observe(10, 0, ack_cyc, rd_cnt, wr_cnt, ic_acks, dc_acks, wr_addr, wr_data);
        check("rd_ack_cyc", ack_cyc, 5);
        check("rd_rd_cnt",  rd_cnt, 4);
        check("rd_wr_cnt",  wr_cnt, 0);
        check("rd_ic_ack",  ic_acks, 0);
        check("rd_dc_ack",  dc_acks, 1);
        check("rd_dc_data", bus4.dc_rdata, {16{8'hA5}});
        check("rd_busy_d",  bus4.busy, 1);
        finish_txn();
        check("rd_idle_busy", bus4.busy, 0);
        check("rd_ack_pulse", bus4.dc_ack, 0);

        // Tie after reset: dc first, then ic, then round-robin continues
        do_reset();
        bus4.ic_req = 1; bus4.ic_addr = 32'h40;
        bus4.dc_req = 1; bus4.dc_addr = 32'h80;
        observe(10, 0, ack_cyc, rd_cnt, wr_cnt, ic_acks, dc_acks, wr_addr, wr_data);
        check("tie1_cyc",   ack_cyc, 5);
        check("tie1_dc",    dc_acks, 1);
        check("tie1_ic",    ic_acks, 0);
        check("tie1_data",  bus4.dc_rdata, mem_model(32'h80));
        bus4.dc_req = 0;
        observe(12, 0, ack_cyc, rd_cnt, wr_cnt, ic_acks, dc_acks, wr_addr, wr_data);
        check("ic2_cyc",    ack_cyc, 6);
        check("ic2_ic",     ic_acks, 1);
        check("ic2_data",   bus4.ic_rdata, mem_model(32'h40));
        check("ic2_dc_hold", bus4.dc_rdata, mem_model(32'h80));
        finish_txn();
        bus4.ic_req = 1; bus4.dc_req = 1;
        observe(10, 0, ack_cyc, rd_cnt, wr_cnt, ic_acks, dc_acks, wr_addr, wr_data);
        check("tie3_dc",    {ic_acks[3:0], dc_acks[3:0]}, 8'h01);
        finish_txn();
        bus4.ic_req = 1; bus4.dc_req = 1;
        observe(10, 0, ack_cyc, rd_cnt, wr_cnt, ic_acks, dc_acks, wr_addr, wr_data);
        check("tie4_ic",    {ic_acks[3:0], dc_acks[3:0]}, 8'h10);
        finish_txn();

        // ic write leaves ic_rdata alone
        bus4.ic_req = 1; bus4.ic_write = 1; bus4.ic_addr = 32'h20; bus4.ic_wdata = 128'h1234;
        observe(10, 0, ack_cyc, rd_cnt, wr_cnt, ic_acks, dc_acks, wr_addr, wr_data);
        check("wr_cyc",     ack_cyc, 5);
        check("wr_cnt",     wr_cnt, 1);
        check("wr_addr",    wr_addr, 32'h20);
        check("wr_data",    wr_data, 128'h1234);
        check("wr_no_read", rd_cnt, 0);
        check("wr_rdata",   bus4.ic_rdata, mem_model(32'h40));
        finish_txn();
        bus4.ic_write = 0;

        // dc read with request dropped and address changed mid-access
        bus4.dc_req = 1; bus4.dc_write = 0; bus4.dc_addr = 32'h30;
        observe(10, 2, ack_cyc, rd_cnt, wr_cnt, ic_acks, dc_acks, wr_addr, wr_data);
        check("chg_cyc",    ack_cyc, 5);
        check("chg_dc",     dc_acks, 1);
        check("chg_addr",   bus4.mem_addr, 32'h30);
        check("chg_data",   bus4.dc_rdata, mem_model(32'h30));
        finish_txn();

        // Reset in the second BUSY cycle of a dc write
        bus4.dc_req = 1; bus4.dc_write = 1; bus4.dc_addr = 32'h50; bus4.dc_wdata = 128'hBEEF;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        bus4.dc_req = 0;
        #1;
        check("abt_busy",   bus4.busy, 0);
        check("abt_strobe", {bus4.mem_read, bus4.mem_write, bus4.dc_ack}, 0);
        check("abt_addr",   {bus4.mem_addr, bus4.mem_wdata}, 0);
        check("abt_rdata",  bus4.dc_rdata | bus4.ic_rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        observe(4, 0, ack_cyc, rd_cnt, wr_cnt, ic_acks, dc_acks, wr_addr, wr_data);
        check("abt_no_ack", ack_cyc, -1);
        check("abt_no_wr",  wr_cnt, 0);
        check("abt_idle",   bus4.busy, 0);
        clear_inputs();

        // LATENCY=1: dc holds a read request continuously
        bus1.dc_req = 1; bus1.dc_write = 0; bus1.dc_addr = 32'h10;
        ack_v = '0; busy_v = '0; rd_v = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 11) bus1.dc_req = 0;
            ack_v[k]  = bus1.dc_ack;
            busy_v[k] = bus1.busy;
            rd_v[k]   = bus1.mem_read;
        end
        check("l1_ack_pat",  ack_v, 12'h492);
        check("l1_busy_pat", busy_v, 12'h6DB);
        check("l1_rd_pat",   rd_v, 12'h249);
        check("l1_data",     bus1.dc_rdata, {16{8'hA5}});

        // LATENCY=1: single write strobe in the only BUSY cycle
        bus1.dc_req = 1; bus1.dc_write = 1; bus1.dc_addr = 32'h60; bus1.dc_wdata = 128'h77;
        wr1_cnt = 0; wr1_pos = -1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (bus1.mem_write) begin
                wr1_cnt++;
                wr1_pos = k;
                check("l1_wr_addr", bus1.mem_addr, 32'h60);
            end
            if (bus1.dc_ack) bus1.dc_req = 0;
        end
        check("l1_wr_cnt",   wr1_cnt, 1);
        check("l1_wr_pos",   wr1_pos, 1);
        check("l1_wr_rdata", bus1.dc_rdata, {16{8'hA5}});

        check("exclusive",   n_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
